// File: rtl/dcache_wrb_if.sv
// Handshake and bus bundle between the dcache controller, the write-back
// buffer and data memory. The buffer connects through the slave modport.
interface dcache_wrb_if #(
   parameter int DEPTH      = 4,
   parameter int LINE_WIDTH = 128,
   parameter int ADDR_WIDTH = 32
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   // Eviction side
   logic                  enq_valid_i;
   logic                  enq_ready_o;
   logic [ADDR_WIDTH-1:0] enq_addr_i;
   logic [LINE_WIDTH-1:0] enq_data_i;

   // Miss lookup side
   logic [ADDR_WIDTH-1:0] lookup_addr_i;
   logic                  lookup_hit_o;
   logic [LINE_WIDTH-1:0] lookup_data_o;

   // Memory write side
   logic                  mem_req_o;
   logic                  mem_ack_i;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [LINE_WIDTH-1:0] mem_data_o;

   // Occupancy
   logic [CNT_W-1:0]      count_o;
   logic                  empty_o;

   modport slave (
      input  enq_valid_i, enq_addr_i, enq_data_i, lookup_addr_i, mem_ack_i,
      output enq_ready_o, lookup_hit_o, lookup_data_o,
             mem_req_o, mem_addr_o, mem_data_o, count_o, empty_o
   );

   modport master (
      output enq_valid_i, enq_addr_i, enq_data_i, lookup_addr_i, mem_ack_i,
      input  enq_ready_o, lookup_hit_o, lookup_data_o,
             mem_req_o, mem_addr_o, mem_data_o, count_o, empty_o
   );
endinterface

// File: rtl/dcache_wrb_buffer.sv
// Write-back buffer: a small circular FIFO of evicted dirty lines that
// drains in order to memory, merges repeat evictions of a queued line and
// offers a combinational lookup of pending lines for miss forwarding.
module dcache_wrb_buffer #(
   parameter int DEPTH       = 4,
   parameter int LINE_WIDTH  = 128,
   parameter int ADDR_WIDTH  = 32,
   parameter int OFFSET_BITS = 4
) (
   input logic              clk,
   input logic              rst,
   dcache_wrb_if.slave      bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam int TAG_W = ADDR_WIDTH - OFFSET_BITS;
   localparam int CNT_W = $clog2(DEPTH + 1);

   // Entry storage; the offset bits of the address are never stored.
   logic [DEPTH-1:0]      valid_q, valid_d;
   logic [TAG_W-1:0]      tag_q  [DEPTH];
   logic [TAG_W-1:0]      tag_d  [DEPTH];
   logic [LINE_WIDTH-1:0] data_q [DEPTH];
   logic [LINE_WIDTH-1:0] data_d [DEPTH];

   // Pointers carry a wrap bit above the index to tell full from empty.
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [IDX_W-1:0] head_idx, tail_idx;

   logic             full, empty;
   logic [TAG_W-1:0] enq_tag, lookup_tag;
   logic             merge_hit;
   logic [IDX_W-1:0] merge_idx;
   logic             do_enq, do_deq;

   assign head_idx   = head_q[IDX_W-1:0];
   assign tail_idx   = tail_q[IDX_W-1:0];
   assign empty      = (head_q == tail_q);
   assign full       = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
   assign enq_tag    = bus.enq_addr_i[ADDR_WIDTH-1:OFFSET_BITS];
   assign lookup_tag = bus.lookup_addr_i[ADDR_WIDTH-1:OFFSET_BITS];

   // Find a queued, non-head entry holding the same line as the eviction.
   // The head is excluded because it is already being offered to memory.
   always_comb begin : merge_search
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      merge_hit = 1'b0;
      merge_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (IDX_W'(i) != head_idx) && (tag_q[i] == enq_tag)) begin
            merge_hit = 1'b1;
            merge_idx = IDX_W'(i);
         end
      end
   end

   assign bus.enq_ready_o = !full || merge_hit;
   assign do_enq          = bus.enq_valid_i && bus.enq_ready_o;
   assign do_deq          = !empty && bus.mem_ack_i;

   // Lookup walks oldest to youngest so the youngest match is kept last.
   always_comb begin : lookup_search
      logic [IDX_W-1:0] idx;
      bus.lookup_hit_o  = 1'b0;
      bus.lookup_data_o = '0;
      idx               = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_idx + IDX_W'(k);
         if (valid_q[idx] && (tag_q[idx] == lookup_tag)) begin
            bus.lookup_hit_o  = 1'b1;
            bus.lookup_data_o = data_q[idx];
         end
      end
   end

   // Head entry is presented to memory straight from registers.
   assign bus.mem_req_o  = !empty;
   assign bus.mem_addr_o = empty ? '0 : {tag_q[head_idx], {OFFSET_BITS{1'b0}}};
   assign bus.mem_data_o = empty ? '0 : data_q[head_idx];
   assign bus.count_o    = CNT_W'(tail_q - head_q);
   assign bus.empty_o    = empty;

   // Next-state: retire the head on ack, then merge or append the eviction.
   always_comb begin : next_state
      head_d  = head_q;
      tail_d  = tail_q;
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (do_deq) begin
         valid_d[head_idx] = 1'b0;
         head_d            = head_q + PTR_W'(1);
      end
      if (do_enq) begin
         if (merge_hit) begin
            data_d[merge_idx] = bus.enq_data_i;
         end else begin
            valid_d[tail_idx] = 1'b1;
            tag_d[tail_idx]   = enq_tag;
            data_d[tail_idx]  = bus.enq_data_i;
            tail_d            = tail_q + PTR_W'(1);
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin : state_regs
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge value of every other register.
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         valid_q <= '0;
         // NOTE: the entry array is reset on purpose, so stale line data
         // never appears on memory or lookup outputs after a reset.
         tag_q   <= '{default: '0};
         data_q  <= '{default: '0};
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         valid_q <= valid_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
      end
   end
endmodule

// File: tb/tb_dcache_wrb_buffer.sv
// Self-checking bench for dcache_wrb_buffer: directed scenarios followed by
// random traffic, all compared against a queue-based model of the buffer.
module tb_dcache_wrb_buffer;
   localparam int DEPTH = 4;
   localparam int LW    = 128;
   localparam int AW    = 32;
   localparam int OB    = 4;
   localparam int TW    = AW - OB;
   localparam int CW    = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dcache_wrb_if #(.DEPTH(DEPTH), .LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

   dcache_wrb_buffer #(
      .DEPTH(DEPTH), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .OFFSET_BITS(OB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Model: queue of pending lines, element 0 is the line offered to memory.
   typedef struct {
      logic [TW-1:0] tag;
      logic [LW-1:0] data;
   } ent_t;
   ent_t mq[$];

   function automatic int merge_pos(input logic [TW-1:0] t);
      for (int i = 1; i < mq.size(); i++)
         if (mq[i].tag == t) return i;
      return -1;
   endfunction

   function automatic logic [LW-1:0] fill(input logic [3:0] n);
      return {32{n}};
   endfunction

   // One clock cycle: drive inputs, compare all outputs with the model,
   // then advance the model across the clock edge. Called at a negedge.
   task automatic step(input logic v, input logic [AW-1:0] a, input logic [LW-1:0] d,
                       input logic ack, input logic [AW-1:0] la, input logic r);
      logic [TW-1:0] et, lt;
      int            mp;
      logic          exp_ready, exp_lh;
      logic [LW-1:0] exp_ld;
      logic [AW-1:0] exp_maddr;
      logic [LW-1:0] exp_mdata;
      ent_t          e;
      rst               = r;
      bus.enq_valid_i   = v;
      bus.enq_addr_i    = a;
      bus.enq_data_i    = d;
      bus.mem_ack_i     = ack;
      bus.lookup_addr_i = la;
      #1;
      et        = a[AW-1:OB];
      lt        = la[AW-1:OB];
      mp        = merge_pos(et);
      exp_ready = (mq.size() < DEPTH) || (mp >= 0);
      exp_lh    = 1'b0;
      exp_ld    = '0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
         if (mq[i].tag == lt) begin
            exp_lh = 1'b1;
            exp_ld = mq[i].data;
            break;
         end
      end
      exp_maddr = (mq.size() > 0) ? {mq[0].tag, {OB{1'b0}}} : '0;
      exp_mdata = (mq.size() > 0) ? mq[0].data : '0;
      check("enq_ready",   LW'(bus.enq_ready_o),  LW'(exp_ready));
      check("lookup_hit",  LW'(bus.lookup_hit_o), LW'(exp_lh));
      check("lookup_data", bus.lookup_data_o,     exp_ld);
      check("mem_req",     LW'(bus.mem_req_o),    LW'(mq.size() > 0));
      check("mem_addr",    LW'(bus.mem_addr_o),   LW'(exp_maddr));
      check("mem_data",    bus.mem_data_o,        exp_mdata);
      check("count",       LW'(bus.count_o),      LW'(mq.size()));
      check("empty",       LW'(bus.empty_o),      LW'(mq.size() == 0));
      @(posedge clk);
      if (r) begin
         mq.delete();
      end else begin
         if (v && exp_ready && mp >= 0) mq[mp].data = d;
         if (ack && mq.size() > 0) mq.delete(0);
         if (v && exp_ready && mp < 0) begin
            e.tag  = et;
            e.data = d;
            mq.push_back(e);
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic ack);
      step(1'b0, '0, '0, ack, '0, 1'b0);
   endtask

   task automatic enq(input logic [AW-1:0] a, input logic [LW-1:0] d, input logic ack);
      step(1'b1, a, d, ack, '0, 1'b0);
   endtask

   task automatic drain_all();
      for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
   endtask

   initial begin
      rst               = 1'b1;
      bus.enq_valid_i   = 1'b0;
      bus.enq_addr_i    = '0;
      bus.enq_data_i    = '0;
      bus.mem_ack_i     = 1'b0;
      bus.lookup_addr_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // 1: reset state, no traffic
      idle(1'b0);
      check("t1_ready", LW'(bus.enq_ready_o), LW'(1));
      check("t1_empty", LW'(bus.empty_o),     LW'(1));

      // 2: single line, held while unacknowledged, then one ack
      enq(32'h0000_100C, fill(4'hA), 1'b0);
      check("t2_addr", LW'(bus.mem_addr_o), LW'(32'h0000_1000));
      check("t2_data", bus.mem_data_o,      fill(4'hA));
      repeat (5) idle(1'b0);
      idle(1'b1);
      idle(1'b0);
      check("t2_count", LW'(bus.count_o), LW'(0));

      // 3: fill, hold the fifth line, accept it the cycle after an ack
      for (int i = 1; i <= 4; i++) enq(AW'(32'h1000 * i), fill(4'(i)), 1'b0);
      check("t3_count", LW'(bus.count_o), LW'(4));
      enq(32'h5000, fill(4'h5), 1'b0);
      enq(32'h5000, fill(4'h5), 1'b1);
      enq(32'h5000, fill(4'h5), 1'b0);
      idle(1'b0);
      check("t3_count_after", LW'(bus.count_o),    LW'(4));
      check("t3_head",        LW'(bus.mem_addr_o), LW'(32'h2000));
      drain_all();

      // 4: merge into a non-head entry, drain order and data
      enq(32'h1000, fill(4'hA), 1'b0);
      enq(32'h2000, fill(4'hB), 1'b0);
      enq(32'h2008, fill(4'hC), 1'b0);
      check("t4_count", LW'(bus.count_o), LW'(2));
      check("t4_w0",    bus.mem_data_o,   fill(4'hA));
      idle(1'b1);
      check("t4_w1",    bus.mem_data_o,   fill(4'hC));
      drain_all();

      // 5: lookup hit while pending, miss after drain
      enq(32'h2000, fill(4'hB), 1'b0);
      step(1'b0, '0, '0, 1'b0, 32'h2004, 1'b0);
      check("t5_hit", LW'(bus.lookup_hit_o), LW'(1));
      check("t5_data", bus.lookup_data_o,    fill(4'hB));
      drain_all();
      step(1'b0, '0, '0, 1'b0, 32'h2004, 1'b0);
      check("t5_miss", LW'(bus.lookup_hit_o), LW'(0));

      // 6: merge while full with a same-cycle ack, then reset mid-drain
      for (int i = 1; i <= 4; i++) enq(AW'(32'h1000 * i), fill(4'(i)), 1'b0);
      enq(32'h3000, fill(4'hD), 1'b1);
      step(1'b0, '0, '0, 1'b0, 32'h3000, 1'b0);
      check("t6_count", LW'(bus.count_o),   LW'(3));
      check("t6_merge", bus.lookup_data_o,  fill(4'hD));
      step(1'b0, '0, '0, 1'b0, '0, 1'b1);
      idle(1'b0);
      check("t6_rst_req", LW'(bus.mem_req_o), LW'(0));

      // Random traffic on a small line pool so merges and hits are frequent
      for (int n = 0; n < 2000; n++) begin
         step(($urandom_range(0, 9) < 6),
              AW'(32'h1000 * $urandom_range(1, 6) + $urandom_range(0, 15)),
              {$urandom, $urandom, $urandom, $urandom},
              ($urandom_range(0, 9) < 4),
              AW'(32'h1000 * $urandom_range(1, 6) + $urandom_range(0, 15)),
              ($urandom_range(0, 99) == 0));
      end
      drain_all();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
